// File: rtl/pipe_ctrl_n.sv
// Parametrised pipeline stall/flush controller with ROM/RAM wait-state FSMs,
// deferred wrong-path fetch kill and a saturating stall-cycle counter.

module pipe_wait_fsm #(
  parameter int unsigned LAT = 1
) (
  input  logic CLK,
  input  logic RST,
  input  logic req_i,
  output logic busy_o,
  output logic done_o
);
  localparam int unsigned CW = $clog2(LAT + 1) + 1;
  localparam logic [CW-1:0] ONE  = CW'(1);
  localparam logic [CW-1:0] LAST = CW'(LAT - 1);
  localparam bit MULTI = (LAT > 1);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // cnt counts busy cycles already spent, including the current one
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_o  = 1'b0;
    done_o  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_i && MULTI) begin
          busy_o  = 1'b1;
          cnt_d   = ONE;
          state_d = (LAST == ONE) ? S_DONE : S_BUSY;
        end
      end
      S_BUSY: begin
        busy_o = 1'b1;
        cnt_d  = cnt_q + ONE;
        if (cnt_d == LAST) state_d = S_DONE;
      end
      S_DONE: begin
        done_o  = 1'b1;
        cnt_d   = '0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end
endmodule

module pipe_ctrl_n #(
  parameter int unsigned NSTAGE  = 5,
  parameter int unsigned ROM_LAT = 1,
  parameter int unsigned RAM_LAT = 1,
  parameter int unsigned PERF_W  = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [NSTAGE-1:0] stallreq_i,
  input  logic              flush_req_i,
  input  logic              rom_req_i,
  input  logic              ram_req_i,
  output logic [NSTAGE:0]   stall_o,
  output logic [NSTAGE-1:0] flush_o,
  output logic              rom_busy_o,
  output logic              ram_busy_o,
  output logic              kill_fetch_o,
  output logic [PERF_W-1:0] stall_cyc_o
);
  logic rom_busy_raw, rom_done_raw, ram_busy_raw, ram_done_raw;
  logic rom_busy, rom_done, ram_busy;
  logic kill_pend_q, kill_pend_d;
  logic [PERF_W-1:0] stall_cyc_q, stall_cyc_d;
  logic [NSTAGE-1:0] req;
  logic [NSTAGE:0]   stall;
  logic [NSTAGE-1:0] flush;
  logic              acc, accept, kill;

  pipe_wait_fsm #(.LAT(ROM_LAT)) u_rom_fsm (
    .CLK(CLK), .RST(RST), .req_i(rom_req_i),
    .busy_o(rom_busy_raw), .done_o(rom_done_raw)
  );

  pipe_wait_fsm #(.LAT(RAM_LAT)) u_ram_fsm (
    .CLK(CLK), .RST(RST), .req_i(ram_req_i),
    .busy_o(ram_busy_raw), .done_o(ram_done_raw)
  );

  // Busy is combinational from the request in IDLE, so it must be gated by reset
  assign rom_busy = RST & rom_busy_raw;
  assign rom_done = RST & rom_done_raw;
  assign ram_busy = RST & ram_busy_raw;
  assign kill     = rom_done & kill_pend_q;

  always_comb begin
    req             = stallreq_i;
    req[0]          = stallreq_i[0] | rom_busy;
    req[NSTAGE-2]   = req[NSTAGE-2] | ram_busy;
    stall           = '0;
    acc             = 1'b0;
    // stall_o[j] is set when any stage at or above j-1 requests
    for (int unsigned i = 0; i < NSTAGE; i++) begin
      acc                  = acc | req[NSTAGE-1-i];
      stall[NSTAGE-i]      = acc;
    end
    stall[0] = stall[1];
    flush    = '0;
    for (int unsigned k = 0; k < NSTAGE - 1; k++) begin
      flush[k] = stall[k+1] & ~stall[k+2];
    end
    accept   = flush_req_i & ~stall[2];
    flush[0] = flush[0] | accept | kill;
  end

  assign stall_o      = RST ? stall : '0;
  assign flush_o      = RST ? flush : '1;
  assign rom_busy_o   = rom_busy;
  assign ram_busy_o   = ram_busy;
  assign kill_fetch_o = kill;
  assign stall_cyc_o  = stall_cyc_q;

  // A flush arriving in the DONE cycle is handled by accept alone; busy is 0 there
  always_comb begin
    kill_pend_d = (kill_pend_q & ~rom_done) | (accept & rom_busy);
    stall_cyc_d = stall_cyc_q;
    if (stall_o[0] && (stall_cyc_q != '1)) stall_cyc_d = stall_cyc_q + 1'b1;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      kill_pend_q <= 1'b0;
      stall_cyc_q <= '0;
    end else begin
      kill_pend_q <= kill_pend_d;
      stall_cyc_q <= stall_cyc_d;
    end
  end

  logic unused_ram_done;
  assign unused_ram_done = ram_done_raw;
endmodule

// File: tb/tb_pipe_ctrl_n.sv
// Scoreboard bench for pipe_ctrl_n: directed cycles push expected outputs,
// a negedge monitor pops and compares.

module tb_pipe_ctrl_n;
  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic [4:0] stallreq_i = '0;
  logic       flush_req_i = 1'b0;
  logic       rom_req_i = 1'b0;
  logic       ram_req_i = 1'b0;
  logic [5:0] stall_o;
  logic [4:0] flush_o;
  logic       rom_busy_o, ram_busy_o, kill_fetch_o;
  logic [3:0] stall_cyc_o;

  pipe_ctrl_n #(.NSTAGE(5), .ROM_LAT(4), .RAM_LAT(3), .PERF_W(4)) dut (
    .CLK(CLK), .RST(RST), .stallreq_i(stallreq_i), .flush_req_i(flush_req_i),
    .rom_req_i(rom_req_i), .ram_req_i(ram_req_i), .stall_o(stall_o),
    .flush_o(flush_o), .rom_busy_o(rom_busy_o), .ram_busy_o(ram_busy_o),
    .kill_fetch_o(kill_fetch_o), .stall_cyc_o(stall_cyc_o)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    string      nm;
    logic [5:0] st;
    logic [4:0] fl;
    logic       rb, mb, k;
    logic [3:0] cy;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge CLK);
      if (q.size() > 0) begin
        e = q.pop_front();
        checks++;
        if ({stall_o, flush_o, rom_busy_o, ram_busy_o, kill_fetch_o, stall_cyc_o} !==
            {e.st, e.fl, e.rb, e.mb, e.k, e.cy}) begin
          errors++;
          $display("FAIL %s: got stall=%b flush=%b romb=%b ramb=%b kill=%b cyc=%0d, want stall=%b flush=%b romb=%b ramb=%b kill=%b cyc=%0d",
                   e.nm, stall_o, flush_o, rom_busy_o, ram_busy_o, kill_fetch_o, stall_cyc_o,
                   e.st, e.fl, e.rb, e.mb, e.k, e.cy);
        end
      end
    end
  end

  task automatic push(input string nm, input logic [5:0] st, input logic [4:0] fl,
                      input logic rb, mb, k, input logic [3:0] cy);
    exp_t e;
    e.nm = nm; e.st = st; e.fl = fl; e.rb = rb; e.mb = mb; e.k = k; e.cy = cy;
    q.push_back(e);
  endtask

  task automatic step(input string nm, input logic rst, input logic [4:0] sr,
                      input logic fr, rr, mr,
                      input logic [5:0] st, input logic [4:0] fl,
                      input logic rb, mb, k, input logic [3:0] cy);
    @(posedge CLK);
    #1;
    RST = rst; stallreq_i = sr; flush_req_i = fr; rom_req_i = rr; ram_req_i = mr;
    push(nm, st, fl, rb, mb, k, cy);
  endtask

  initial begin : stim
    step("rst0", 0, 5'b00000, 0, 0, 0, 6'b000000, 5'b11111, 0, 0, 0, 0);
    step("rst1", 0, 5'b00000, 0, 0, 0, 6'b000000, 5'b11111, 0, 0, 0, 0);
    step("idle",       1, 5'b00000, 0, 0, 0, 6'b000000, 5'b00000, 0, 0, 0, 0);
    step("ex_stall",   1, 5'b00100, 0, 0, 0, 6'b001111, 5'b00100, 0, 0, 0, 0);
    step("ex_id",      1, 5'b00110, 0, 0, 0, 6'b001111, 5'b00100, 0, 0, 0, 1);
    step("release",    1, 5'b00000, 0, 0, 0, 6'b000000, 5'b00000, 0, 0, 0, 2);
    step("id_flush",   1, 5'b00010, 1, 0, 0, 6'b000111, 5'b00010, 0, 0, 0, 2);
    step("br_flush",   1, 5'b00000, 1, 0, 0, 6'b000000, 5'b00001, 0, 0, 0, 3);
    step("ram_b1",     1, 5'b00000, 0, 0, 1, 6'b011111, 5'b01000, 0, 1, 0, 3);
    step("ram_b2",     1, 5'b00000, 0, 0, 0, 6'b011111, 5'b01000, 0, 1, 0, 4);
    step("ram_done",   1, 5'b00000, 0, 0, 0, 6'b000000, 5'b00000, 0, 0, 0, 5);
    step("ram_idle",   1, 5'b00000, 0, 0, 0, 6'b000000, 5'b00000, 0, 0, 0, 5);
    step("rom_b1",     1, 5'b00000, 0, 1, 0, 6'b000011, 5'b00001, 1, 0, 0, 5);
    step("rom_b2_fl",  1, 5'b00000, 1, 0, 0, 6'b000011, 5'b00001, 1, 0, 0, 6);
    step("rom_b3",     1, 5'b00000, 0, 0, 0, 6'b000011, 5'b00001, 1, 0, 0, 7);
    step("rom_kill",   1, 5'b00000, 0, 0, 0, 6'b000000, 5'b00001, 0, 0, 1, 8);
    step("kill_clr",   1, 5'b00000, 0, 0, 0, 6'b000000, 5'b00000, 0, 0, 0, 8);
    step("rom2_b1",    1, 5'b00000, 0, 1, 0, 6'b000011, 5'b00001, 1, 0, 0, 8);
    step("rom2_b2",    1, 5'b00000, 0, 0, 0, 6'b000011, 5'b00001, 1, 0, 0, 9);
    step("rom2_b3",    1, 5'b00000, 0, 0, 0, 6'b000011, 5'b00001, 1, 0, 0, 10);
    step("done_flush", 1, 5'b00000, 1, 0, 0, 6'b000000, 5'b00001, 0, 0, 0, 11);
    step("no_pend",    1, 5'b00000, 0, 0, 0, 6'b000000, 5'b00000, 0, 0, 0, 11);
    // reset asserted in the middle of RAM busy cycle 1
    @(posedge CLK);
    #1;
    ram_req_i = 1'b1;
    #2;
    RST = 1'b0;
    push("mid_rst", 6'b000000, 5'b11111, 0, 0, 0, 0);
    step("post_rst",   1, 5'b00000, 0, 0, 0, 6'b000000, 5'b00000, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      step("sat", 1, 5'b00001, 0, 0, 0, 6'b000011, 5'b00001, 0, 0, 0,
           (i > 15) ? 4'd15 : 4'(i));
    end
    step("sat_hold",   1, 5'b00000, 0, 0, 0, 6'b000000, 5'b00000, 0, 0, 0, 15);
    @(negedge CLK);
    #1;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending, want 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
